// File: rtl/gf2m_systolic_pe_p_pkg.sv
// Shared constants for the GF(2^m) digit-serial systolic PE: default geometry,
// field size and the NIST B-163 style reduction polynomial.
package gf2m_systolic_pe_p_pkg;

  localparam int DIGITS_DEF = 16;
  localparam int NDIG_DEF   = 11;
  localparam int FIELD_M    = 163;

  // x^163 + x^7 + x^6 + x^3 + 1
  localparam logic [FIELD_M:0] REDUCTION_POLY = {1'b1, 155'd0, 8'hC9};

  // Digit counter needs at least one bit even for single-digit words
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/gf2m_systolic_pe_p_clmul.sv
// Pure combinational carry-less (GF(2)[x]) multiplier of two DIGITS-bit digits.
module gf2m_systolic_pe_p_clmul #(
  parameter int DIGITS = 16
) (
  input  logic [DIGITS-1:0]   x,
  input  logic [DIGITS-1:0]   y,
  output logic [2*DIGITS-2:0] p
);

  logic [2*DIGITS-2:0] acc_s;

  // XOR-accumulate shifted partial products, one per set bit of y
  always_comb begin
    acc_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      acc_s = acc_s ^ ({{(DIGITS-1){1'b0}}, x & {DIGITS{y[i]}}} << i);
    end
  end

  assign p = acc_s;

endmodule

// File: rtl/gf2m_systolic_pe_p.sv
// Digit-serial systolic PE for GF(2^m) multiply with interleaved reduction.
// Define GF_PE_OUT_REG_EN to add a second output register stage (latency 2).
module gf2m_systolic_pe_p
  import gf2m_systolic_pe_p_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int NDIG   = NDIG_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              vld_in,
  input  logic              first_in,
  input  logic [DIGITS-1:0] a_in,
  input  logic [DIGITS-1:0] b_in,
  input  logic [DIGITS-1:0] q_in,
  input  logic [DIGITS-1:0] g_in,
  input  logic [DIGITS-1:0] t_in,
  output logic              vld_out,
  output logic              first_out,
  output logic              last_out,
  output logic [DIGITS-1:0] a_out,
  output logic [DIGITS-1:0] b_out,
  output logic [DIGITS-1:0] q_out,
  output logic [DIGITS-1:0] g_out,
  output logic [DIGITS-1:0] t_out,
  output logic [DIGITS-2:0] carry_out,
  output logic              err
);

  localparam int CW = cnt_width(NDIG);
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
  // Output bundle: {vld, first, last, err, a, b, q, g, t, carry}
  localparam int DW = 5 * DIGITS + (DIGITS - 1);
  localparam int OW = 4 + DW;

  logic [CW-1:0]       cnt_r;
  logic [DIGITS-1:0]   b_hold_r;
  logic [DIGITS-2:0]   carry_r;
  logic                err_r;
  logic [OW-1:0]       stage1_r;
  logic [OW-1:0]       out_s;

  logic                accept_s;
  logic                first_s;
  logic                err_set_s;
  logic [DIGITS-1:0]   b_eff_s;
  logic [DIGITS-2:0]   carry_eff_s;
  logic [2*DIGITS-2:0] p_ab_s;
  logic [2*DIGITS-2:0] p_qg_s;
  logic [2*DIGITS-2:0] p_s;
  logic [DIGITS-1:0]   t_nxt_s;
  logic [CW-1:0]       cnt_cur_s;
  logic [CW-1:0]       cnt_nxt_s;
  logic                last_s;
  logic [OW-1:0]       out_nxt_s;

  gf2m_systolic_pe_p_clmul #(.DIGITS(DIGITS)) u_clmul_ab (
    .x (a_in),
    .y (b_eff_s),
    .p (p_ab_s)
  );

  gf2m_systolic_pe_p_clmul #(.DIGITS(DIGITS)) u_clmul_qg (
    .x (q_in),
    .y (g_in),
    .p (p_qg_s)
  );

  // Digit datapath; a missing first digit (cnt=0) is recovered by treating the digit as first
  always_comb begin
    accept_s    = en & vld_in;
    first_s     = first_in | (cnt_r == '0);
    err_set_s   = accept_s & (first_in ^ (cnt_r == '0));
    b_eff_s     = first_s ? b_in : b_hold_r;
    carry_eff_s = first_s ? '0 : carry_r;
    p_s         = p_ab_s ^ p_qg_s;
    t_nxt_s     = t_in ^ p_s[DIGITS-1:0] ^ {1'b0, carry_eff_s};
    cnt_cur_s   = first_s ? '0 : cnt_r;
    last_s      = (cnt_cur_s == CNT_LAST);
    cnt_nxt_s   = last_s ? '0 : cnt_cur_s + CW'(1);
    if (accept_s) begin
      out_nxt_s = {1'b1, first_in, last_s, err_r | err_set_s,
                   a_in, b_in, q_in, g_in, t_nxt_s,
                   last_s ? p_s[2*DIGITS-2:DIGITS] : {(DIGITS-1){1'b0}}};
    end else begin
      // Bubble: drop the valid/flag bits, keep the data fields stable
      out_nxt_s = {1'b0, 1'b0, 1'b0, err_r,
                   stage1_r[DW-1:DIGITS-1], {(DIGITS-1){1'b0}}};
    end
  end

  // Word state and first output stage; en=0 freezes everything
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r    <= '0;
      b_hold_r <= '0;
      carry_r  <= '0;
      err_r    <= 1'b0;
      stage1_r <= '0;
    end else if (en) begin
      stage1_r <= out_nxt_s;
      if (accept_s) begin
        cnt_r   <= cnt_nxt_s;
        carry_r <= p_s[2*DIGITS-2:DIGITS];
        err_r   <= err_r | err_set_s;
        if (first_s) begin
          b_hold_r <= b_in;
        end
      end
    end
  end

`ifdef GF_PE_OUT_REG_EN
  logic [OW-1:0] stage2_r;

  // Optional retiming stage for long PE chains
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage2_r <= '0;
    end else if (en) begin
      stage2_r <= stage1_r;
    end
  end

  assign out_s = stage2_r;
`else
  assign out_s = stage1_r;
`endif

  assign {vld_out, first_out, last_out, err,
          a_out, b_out, q_out, g_out, t_out, carry_out} = out_s;

endmodule

// File: tb/tb_gf2m_systolic_pe_p.sv
// Scoreboard bench for gf2m_systolic_pe_p at D=4, NDIG=3 with hand-computed digit results.
module tb_gf2m_systolic_pe_p;

`ifdef GF_PE_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rstn, en, vld_in, first_in;
  logic [3:0] a_in, b_in, q_in, g_in, t_in;
  logic       vld_out, first_out, last_out, err;
  logic [3:0] a_out, b_out, q_out, g_out, t_out;
  logic [2:0] carry_out;

  int tests = 0;
  int fails = 0;
  logic en_seen = 1'b0;

  // Expected digit: {t, first, last, carry, a, b, q, g}
  logic [26:0] exp_q [$];

  gf2m_systolic_pe_p #(.DIGITS(4), .NDIG(3)) dut (
    .clk(clk), .rstn(rstn), .en(en), .vld_in(vld_in), .first_in(first_in),
    .a_in(a_in), .b_in(b_in), .q_in(q_in), .g_in(g_in), .t_in(t_in),
    .vld_out(vld_out), .first_out(first_out), .last_out(last_out),
    .a_out(a_out), .b_out(b_out), .q_out(q_out), .g_out(g_out), .t_out(t_out),
    .carry_out(carry_out), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) en_seen = en;

  // Monitor: each fresh valid output is popped and compared
  always @(negedge clk) begin
    logic [26:0] e;
    logic [26:0] act;
    if (rstn && en_seen && vld_out) begin
      tests++;
      act = {t_out, first_out, last_out, carry_out, a_out, b_out, q_out, g_out};
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output got=%h required=<none>", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL digit t/f/l/c/a/b/q/g got=%h %b %b %h %h %h %h %h required=%h %b %b %h %h %h %h %h",
                   act[26:23], act[22], act[21], act[20:18], act[17:14], act[13:10], act[9:6], act[5:2],
                   e[26:23], e[22], e[21], e[20:18], e[17:14], e[13:10], e[9:6], e[5:2]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic f, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] q, input logic [3:0] g, input logic [3:0] t,
                      input logic [3:0] et, input logic el, input logic [2:0] ec);
    exp_q.push_back({et, f, el, ec, a, b, q, g});
    en = 1'b1; vld_in = 1'b1; first_in = f;
    a_in = a; b_in = b; q_in = q; g_in = g; t_in = t;
    @(posedge clk); #1;
    vld_in = 1'b0; first_in = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b1; vld_in = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic stall(input int n);
    en = 1'b0; vld_in = 1'b1; first_in = 1'b1; a_in = 4'h7;
    repeat (n) begin @(posedge clk); #1; end
    en = 1'b1; vld_in = 1'b0; first_in = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    idle(LAT);
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("reset_outputs", {5'd0, vld_out, first_out, last_out, a_out, b_out, q_out,
                          g_out, t_out, carry_out, err}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; vld_in = 1'b0; first_in = 1'b0;
    a_in = 4'h0; b_in = 4'h0; q_in = 4'h0; g_in = 4'h0; t_in = 4'h0;
    repeat (2) @(posedge clk);
    do_reset();

    // 3*3 = 101, padded to a full word
    send(1'b1, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'h0);
    send(1'b0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'h0);
    send(1'b0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 3'h0);

    // F*F = 1010101: low 5, high 5 carried into digit 1
    send(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'h0);
    send(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'h0);
    send(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 3'h0);

    // Same word with bubbles between digits
    send(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'h0);
    idle(2);
    send(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'h0);
    idle(1);
    send(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 3'h0);

    // b=5: 3*5=F; 6*5=1E -> E, carry 1; 9*5=2D -> D^1^t(3)=F, final carry 2
    send(1'b1, 4'h3, 4'h5, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 3'h0);
    send(1'b0, 4'h6, 4'h5, 4'h0, 4'h0, 4'h0, 4'hE, 1'b0, 3'h0);
    send(1'b0, 4'h9, 4'h5, 4'h0, 4'h0, 4'h3, 4'hF, 1'b1, 3'h2);

    // Reduction term: 3*5 = F, t = A^F = 5, side-band digits forwarded
    send(1'b1, 4'h0, 4'h6, 4'h3, 4'h5, 4'hA, 4'h5, 1'b0, 3'h0);
    send(1'b0, 4'h0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'h0);
    send(1'b0, 4'h0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 3'h0);

    // Stall mid-word with vld_in=1 and a junk first digit: must not be taken
    send(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'h0);
    stall(3);
    send(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'h0);
    send(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 3'h0);
    drain();
    chk("err_clean_stream", 32'(err), 32'd0);

    // Premature first at cnt=2: restart, sticky error
    send(1'b1, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'h0);
    send(1'b0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'h0);
    send(1'b1, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'h0);
    idle(LAT - 1);
    chk("err_first_midword", 32'(err), 32'd1);
    send(1'b0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'h0);
    send(1'b0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 3'h0);
    drain();
    chk("err_sticky", 32'(err), 32'd1);

    // Missing first at cnt=0: treated as first, b captured
    do_reset();
    send(1'b0, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'h0);
    idle(LAT - 1);
    chk("err_missing_first", 32'(err), 32'd1);
    send(1'b0, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'h0);
    send(1'b0, 4'h3, 4'h9, 4'h0, 4'h0, 4'h0, 4'h5, 1'b1, 3'h0);
    drain();

    // Reset pulse mid-word drops the word; a fresh word then runs cleanly
    do_reset();
    send(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'h0);
    drain();
    do_reset();
    send(1'b1, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h5, 1'b0, 3'h0);
    send(1'b0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'h0);
    send(1'b0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 3'h0);
    drain();
    chk("err_after_reset", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
